// File: rtl/spart_tx_arbiter.sv
// Round-robin arbiter that frames 16-bit words from two requesters into paced SPART byte writes.
// Define SPART_TX_CSUM_EN to append an XOR checksum byte to every frame.
module spart_tx_arbiter #(
   parameter logic [4:0]  HDR_TAG    = 5'b10100,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   input  logic [15:0] req_data0,
   input  logic [1:0]  req_addr0,
   input  logic [15:0] req_data1,
   input  logic [1:0]  req_addr1,
   output logic [1:0]  req_ack,
   input  logic        tbr,
   output logic        write,
   output logic [7:0]  data_out,
   output logic [1:0]  grant,
   output logic        busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LATCH = 2'd1;
   localparam logic [1:0] S_SEND  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

`ifdef SPART_TX_CSUM_EN
   localparam logic [1:0] LAST_IDX = 2'd3;
`else
   localparam logic [1:0] LAST_IDX = 2'd2;
`endif

   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

   logic [1:0]  r_state;
   logic        r_last;
   logic        r_id;
   logic [1:0]  r_addr;
   logic [15:0] r_data;
   logic [1:0]  r_idx;
   logic [3:0]  r_gap;
   logic [1:0]  r_ack;
   logic [1:0]  r_grant;
   logic        r_busy;
   logic [7:0]  r_dout;

   logic        w_pick;
   logic        w_strobe;
   logic [7:0]  w_header;
   logic [7:0]  w_byte;

   // On a tie the requester that was not served last wins.
   always_comb begin
      w_pick = req_valid[1];
      if (req_valid == 2'b11) begin
         w_pick = ~r_last;
      end
   end

   assign w_header = {HDR_TAG, r_id, r_addr};

   always_comb begin
      w_byte = w_header;
      case (r_idx)
         2'd1:    w_byte = r_data[15:8];
         2'd2:    w_byte = r_data[7:0];
`ifdef SPART_TX_CSUM_EN
         2'd3:    w_byte = w_header ^ r_data[15:8] ^ r_data[7:0];
`endif
         default: w_byte = w_header;
      endcase
   end

   // The strobe fires in the same cycle tbr is seen high; data_out keeps the last byte otherwise.
   assign w_strobe = (r_state == S_SEND) && tbr;
   assign write    = w_strobe;
   assign data_out = w_strobe ? w_byte : r_dout;
   assign req_ack  = r_ack;
   assign grant    = r_grant;
   assign busy     = r_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_id    <= 1'b0;
         r_addr  <= 2'b00;
         r_data  <= 16'h0000;
         r_idx   <= 2'd0;
         r_gap   <= 4'd0;
         r_ack   <= 2'b00;
         r_grant <= 2'b00;
         r_busy  <= 1'b0;
         r_dout  <= 8'h00;
      end else begin
         r_ack <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (|req_valid) begin
                  r_id    <= w_pick;
                  r_ack   <= w_pick ? 2'b10 : 2'b01;
                  r_grant <= w_pick ? 2'b10 : 2'b01;
                  r_busy  <= 1'b1;
                  r_state <= S_LATCH;
               end
            end
            S_LATCH: begin
               r_data  <= r_id ? req_data1 : req_data0;
               r_addr  <= r_id ? req_addr1 : req_addr0;
               r_last  <= r_id;
               r_idx   <= 2'd0;
               r_state <= S_SEND;
            end
            S_SEND: begin
               if (tbr) begin
                  r_dout  <= w_byte;
                  r_gap   <= GAP_LOAD;
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               if (r_gap <= 4'd1) begin
                  if (r_idx == LAST_IDX) begin
                     r_grant <= 2'b00;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_idx   <= r_idx + 2'd1;
                     r_state <= S_SEND;
                  end
               end else begin
                  r_gap <= r_gap - 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
